counter_wrap_max: RTL and testbench

- Programmable-modulus up-counter with a run-time limit `max`.
- Counts enabled cycles from 0 to `max`, then wraps to 0.
- Flags the terminal count with the `pls` output.
- Used as a divider or timebase for strobes, baud ticks and frame counters; two interchangeable micro-architectures are selectable by parameter.

---
 rtl/counter_wrap_max.sv | 48 ++++
 tb/tb_counter_wrap_max.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/counter_wrap_max.sv
// rtl/counter_wrap_max.sv - programmable-modulus up-counter wrapping at a run-time limit
module counter_wrap_max #(
    parameter int WIDTH          = 4,
    parameter int IMPLEMENTATION = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] cnt,
    output logic             pls
);

    logic [WIDTH-1:0] cnt_inc;
    logic             is_max;

    generate
        if (IMPLEMENTATION == 0) begin : g_beh
            assign is_max  = (cnt == max);
            assign cnt_inc = cnt + WIDTH'(1);
        end else begin : g_struct
            logic [WIDTH-1:0] eq_bits;
            logic [WIDTH-1:0] carry;

            // Half-adder chain: carry into bit i is the AND of all lower bits.
            assign carry[0] = 1'b1;
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                assign eq_bits[i] = ~(cnt[i] ^ max[i]);
                assign cnt_inc[i] = cnt[i] ^ carry[i];
                if (i > 0) begin : g_carry
                    assign carry[i] = cnt[i-1] & carry[i-1];
                end
            end
            assign is_max = &eq_bits;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (ena) begin
            cnt <= is_max ? '0 : cnt_inc;
        end
    end

    assign pls = is_max;

endmodule

// File: tb/tb_counter_wrap_max.sv
// tb/tb_counter_wrap_max.sv - random and directed checks of both counter_wrap_max variants against a reference model
module tb_counter_wrap_max;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [3:0] max;
    logic [3:0] cnt0, cnt1;
    logic       pls0, pls1;

    int vectors     = 0;
    int miscompares = 0;
    int ref_cnt     = 0;
    int en_cnt;
    logic e;
    logic [3:0] m;
    int lower_exp [10] = '{11, 12, 13, 14, 15, 0, 1, 2, 3, 0};

    counter_wrap_max #(.WIDTH(4), .IMPLEMENTATION(0)) u_beh (
        .clk(clk), .rst(rst), .ena(ena), .max(max), .cnt(cnt0), .pls(pls0)
    );

    counter_wrap_max #(.WIDTH(4), .IMPLEMENTATION(1)) u_struct (
        .clk(clk), .rst(rst), .ena(ena), .max(max), .cnt(cnt1), .pls(pls1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_both(input string tag);
        chk({tag, "_cnt_beh"}, 32'(cnt0), 32'(ref_cnt));
        chk({tag, "_cnt_struct"}, 32'(cnt1), 32'(ref_cnt));
        chk({tag, "_pls_beh"}, 32'(pls0), 32'(ref_cnt == int'(max)));
        chk({tag, "_pls_struct"}, 32'(pls1), 32'(ref_cnt == int'(max)));
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cycle(input string tag, input logic en_v, input logic [3:0] max_v);
        ena = en_v;
        max = max_v;
        #1;
        chk_both({tag, "_pre"});
        if (en_v) ref_cnt = (ref_cnt == int'(max_v)) ? 0 : (ref_cnt + 1) % 16;
        @(posedge clk);
        #1;
        chk_both({tag, "_post"});
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag, input logic [3:0] max_v);
        rst = 1'b0;
        ena = 1'b1;
        max = max_v;
        ref_cnt = 0;
        #1;
        chk_both({tag, "_rst"});
        repeat (4) begin
            @(negedge clk);
            #1;
            chk_both({tag, "_rst_hold"});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        ena = 1'b0;
        max = 4'd0;
        @(negedge clk);

        // max = 0: stuck at zero with pls high, whatever ena does
        do_reset("t1", 4'd0);
        en_cnt = 0;
        for (int i = 0; i < 200 && en_cnt < 18; i++) begin
            e = 1'($urandom_range(0, 1));
            if (e) en_cnt++;
            cycle("t1", e, 4'd0);
        end

        // max = 1: toggling 0,1,0,1
        do_reset("t2", 4'd1);
        for (int i = 1; i <= 10; i++) begin
            cycle("t2", 1'b1, 4'd1);
            chk("t2_alt", 32'(cnt0), 32'(i % 2));
        end

        // max = 15: full binary count with random ena
        do_reset("t3", 4'd15);
        en_cnt = 0;
        for (int i = 0; i < 300 && en_cnt < 40; i++) begin
            e = 1'($urandom_range(0, 1));
            if (e) en_cnt++;
            cycle("t3", e, 4'd15);
        end

        // limit lowered below the count: overflow through 15 then wrap at 3
        do_reset("t4", 4'd15);
        for (int i = 0; i < 10; i++) cycle("t4_run", 1'b1, 4'd15);
        chk("t4_at10", 32'(cnt0), 32'd10);
        for (int i = 0; i < 10; i++) begin
            cycle("t4_low", 1'b1, 4'd3);
            chk("t4_seq_beh", 32'(cnt0), 32'(lower_exp[i]));
            chk("t4_seq_struct", 32'(cnt1), 32'(lower_exp[i]));
        end

        // asynchronous reset between edges
        do_reset("t5", 4'd15);
        for (int i = 0; i < 7; i++) cycle("t5_run", 1'b1, 4'd15);
        chk("t5_at7", 32'(cnt0), 32'd7);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_async_cnt_beh", 32'(cnt0), 32'd0);
        chk("t5_async_cnt_struct", 32'(cnt1), 32'd0);
        chk("t5_async_pls_beh", 32'(pls0), 32'd0);
        chk("t5_async_pls_struct", 32'(pls1), 32'd0);
        ref_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        cycle("t5_rel", 1'b1, 4'd15);
        chk("t5_first", 32'(cnt0), 32'd1);

        // equivalence: both variants vs model for max 0, 1, 15, then free-running max
        do_reset("t6", 4'd0);
        for (int p = 0; p < 3; p++) begin
            m = (p == 0) ? 4'd0 : (p == 1) ? 4'd1 : 4'd15;
            for (int i = 0; i < 60; i++) begin
                e = 1'($urandom_range(0, 1));
                cycle("t6_fix", e, m);
            end
        end
        for (int i = 0; i < 200; i++) begin
            e = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) m = 4'($urandom_range(0, 15));
            cycle("t6_rnd", e, m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
